// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared state type, default parameters and counter sizing
package pdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } pdm_state_t;

  localparam int DEF_CLK_HALF_DIV    = 20;
  localparam int DEF_WARMUP_CLKS     = 32768;
  localparam int DEF_DISCARD_SAMPLES = 4;

  // Width able to hold 0..n, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// rtl/pdm_clk_gen.sv - microphone clock divider with rising-edge strobe
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int CLK_HALF_DIV = DEF_CLK_HALF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic MIC_CLK,
  output logic m_clk_rising
);

  localparam int DW = cnt_width(CLK_HALF_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_HALF_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          terminal;

  assign terminal = (div_cnt == DIV_LAST);

  // Strobe is registered alongside MIC_CLK so both rise in the same cycle
  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      div_cnt      <= '0;
      MIC_CLK      <= 1'b0;
      m_clk_rising <= 1'b0;
    end else begin
      m_clk_rising <= terminal && !MIC_CLK;
      if (terminal) begin
        div_cnt <= '0;
        MIC_CLK <= ~MIC_CLK;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdm_mic_ctrl.sv
// rtl/pdm_mic_ctrl.sv - PDM microphone sequencer: warm-up, CIC settle, PCM forwarding
module pdm_mic_ctrl
  import pdm_pkg::*;
#(
  parameter int CLK_HALF_DIV    = DEF_CLK_HALF_DIV,
  parameter int WARMUP_CLKS     = DEF_WARMUP_CLKS,
  parameter int DISCARD_SAMPLES = DEF_DISCARD_SAMPLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       MIC_CLK,
  output logic       m_clk_rising,
  output logic       cic_aresetn,
  input  logic [7:0] cic_data,
  input  logic       cic_valid,
  output logic [7:0] pcm_data,
  output logic       pcm_valid,
  input  logic       pcm_ready,
  output logic [1:0] state,
  output logic       overrun
);

  localparam int WW = cnt_width(WARMUP_CLKS);
  localparam int SW = cnt_width(DISCARD_SAMPLES);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CLKS - 1);
  localparam logic [SW-1:0] SET_LAST  = SW'(DISCARD_SAMPLES - 1);

  pdm_state_t    st, st_next;
  logic [WW-1:0] warm_cnt;
  logic [SW-1:0] set_cnt;
  logic          warm_done, settle_done, run;

  assign state       = st;
  assign cic_aresetn = (st == ST_SETTLE) || (st == ST_RUN);
  // Dropping enable stops the divider on the same edge the FSM returns to IDLE
  assign run         = enable && (st != ST_IDLE);
  assign warm_done   = (WARMUP_CLKS == 0) || (m_clk_rising && warm_cnt == WARM_LAST);
  assign settle_done = (DISCARD_SAMPLES == 0) || (cic_valid && set_cnt == SET_LAST);

  pdm_clk_gen #(.CLK_HALF_DIV(CLK_HALF_DIV)) u_clk_gen (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .MIC_CLK      (MIC_CLK),
    .m_clk_rising (m_clk_rising)
  );

  always_ff @(posedge clk) begin
    if (!rst) st <= ST_IDLE;
    else      st <= st_next;
  end

  always_comb begin
    st_next = st;
    case (st)
      ST_IDLE:   if (enable) st_next = ST_WARMUP;
      ST_WARMUP: if (!enable) st_next = ST_IDLE;
                 else if (warm_done) st_next = (DISCARD_SAMPLES == 0) ? ST_RUN : ST_SETTLE;
      ST_SETTLE: if (!enable) st_next = ST_IDLE;
                 else if (settle_done) st_next = ST_RUN;
      ST_RUN:    if (!enable) st_next = ST_IDLE;
      default:   st_next = ST_IDLE;
    endcase
  end

  // Counters saturate on their last value; the state change clears them
  always_ff @(posedge clk) begin
    if (!rst || !enable || st != ST_WARMUP) warm_cnt <= '0;
    else if (m_clk_rising && warm_cnt != WARM_LAST) warm_cnt <= warm_cnt + 1'b1;

    if (!rst || !enable || st != ST_SETTLE) set_cnt <= '0;
    else if (cic_valid && set_cnt != SET_LAST) set_cnt <= set_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (st == ST_IDLE && enable) overrun <= 1'b0;
      if (!enable) begin
        pcm_valid <= 1'b0;
      end else if (st == ST_RUN) begin
        if (cic_valid) begin
          pcm_data  <= cic_data;
          pcm_valid <= 1'b1;
          if (pcm_valid && !pcm_ready) overrun <= 1'b1;
        end else if (pcm_ready) begin
          pcm_valid <= 1'b0;
        end
      end
    end
  end

endmodule
